// File: rtl/pipe_pkg.sv
// pipe_pkg: skid-stage state encoding and occupancy-counter width helper.
package pipe_pkg;
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_HALF  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;
  function automatic int cw_of(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/pipe_skid_chain_if.sv
// pipe_skid_chain_if: producer/consumer handshake bundle for pipe_skid_chain.
// stall_cnt exists only when PIPE_SKID_STAT_EN is defined.
interface pipe_skid_chain_if #(
  parameter int N  = 32,
  parameter int CW = 2
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] occupancy;
`ifdef PIPE_SKID_STAT_EN
  logic [31:0]   stall_cnt;
  modport master (output flush, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, occupancy, stall_cnt);
  modport slave (input flush, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, occupancy, stall_cnt);
`else
  modport master (output flush, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, occupancy);
  modport slave (input flush, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, occupancy);
`endif
endinterface

// File: rtl/skid_slot.sv
// skid_slot: one registered stage with main/skid regs; ready comes straight from the skid valid flop.
module skid_slot
  import pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         up_valid_i,
  input  logic [N-1:0] up_data_i,
  output logic         up_ready_o,
  output logic         dn_valid_o,
  input  logic         dn_ready_i,
  output logic [N-1:0] dn_data_o
);
  logic         m_v_q, m_v_d, s_v_q, s_v_d, acc, take;
  logic [N-1:0] m_q, m_d, s_q, s_d;
  skid_state_e  st;
  always_comb begin
    st    = s_v_q ? SKID_FULL : (m_v_q ? SKID_HALF : SKID_EMPTY);
    acc   = up_valid_i && !s_v_q;
    take  = m_v_q && dn_ready_i;
    m_v_d = !flush_i && ((st == SKID_EMPTY) ? acc : ((st == SKID_FULL) || acc || !take));
    s_v_d = !flush_i && ((st == SKID_FULL) ? !take : ((st == SKID_HALF) && acc && !take));
    m_d   = ((st == SKID_FULL) && take) ? s_q
          : (acc && ((st == SKID_EMPTY) || take)) ? up_data_i : m_q;
    s_d   = ((st == SKID_HALF) && acc && !take) ? up_data_i : s_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      m_q   <= m_d;
      s_q   <= s_d;
    end
  assign up_ready_o = !s_v_q;
  assign dn_valid_o = m_v_q;
  assign dn_data_o  = m_q;
endmodule

// File: rtl/pipe_skid_chain.sv
// pipe_skid_chain: DEPTH chained skid stages with flush and occupancy count.
// Define PIPE_SKID_STAT_EN to add the saturating stall_cnt output.
module pipe_skid_chain
  import pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_skid_chain_if.slave bus
);
  localparam int CW = cw_of(DEPTH);
  logic [DEPTH:0] v, r;
  logic [N-1:0]   d [DEPTH+1];
  logic           in_xfer, out_xfer;
  logic [CW-1:0]  occ_q, occ_d;
  assign v[0]     = bus.in_valid;
  assign d[0]     = bus.in_data;
  assign r[DEPTH] = bus.out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    skid_slot #(.N(N)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (bus.flush),
      .up_valid_i (v[i]),
      .up_data_i  (d[i]),
      .up_ready_o (r[i]),
      .dn_valid_o (v[i+1]),
      .dn_ready_i (r[i+1]),
      .dn_data_o  (d[i+1])
    );
  end
  // Flush blocks new input but lets the head drain in the same cycle.
  assign bus.in_ready  = r[0] && !bus.flush && rst_n;
  assign bus.out_valid = v[DEPTH];
  assign bus.out_data  = d[DEPTH];
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = v[DEPTH] && r[DEPTH];
  assign occ_d    = bus.flush ? '0 : occ_q + CW'(in_xfer) - CW'(out_xfer);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occ_q <= '0;
    else occ_q <= occ_d;
  assign bus.occupancy = occ_q;
`ifdef PIPE_SKID_STAT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = (v[DEPTH] && !r[DEPTH] && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  assign bus.stall_cnt = stall_q;
`endif
endmodule
